// File: rtl/vending_controller_if.sv
// vending_controller_if: bundles the vending controller's panel, sensor and solenoid signals.
// Ports (signals):
//   coin_valid, coin[4:0]      - coin acceptor: strobe and one-hot coin code
//   item_select, vend_req      - item panel: one-hot choice and purchase strobe
//   cancel                     - refund request
//   item_avail, bank_avail     - inventory and change-bank sensors
//   credit                     - current credit in nickels
//   dispense_item, change_coin - one-cycle solenoid pulses
//   coin_reject, vend_deny, change_short, busy - status flags
// The controller uses the slave modport; the environment drives through master.
interface vending_controller_if #(
    parameter int NUM_ITEMS = 6,
    parameter int CREDIT_W  = 8
);
    logic                 coin_valid;
    logic [4:0]           coin;
    logic [NUM_ITEMS-1:0] item_select;
    logic                 vend_req;
    logic                 cancel;
    logic [NUM_ITEMS-1:0] item_avail;
    logic [4:0]           bank_avail;
    logic [CREDIT_W-1:0]  credit;
    logic [NUM_ITEMS-1:0] dispense_item;
    logic [4:0]           change_coin;
    logic                 coin_reject;
    logic                 vend_deny;
    logic                 change_short;
    logic                 busy;

    modport master (
        output coin_valid, coin, item_select, vend_req, cancel, item_avail, bank_avail,
        input  credit, dispense_item, change_coin, coin_reject, vend_deny, change_short, busy
    );

    modport slave (
        input  coin_valid, coin, item_select, vend_req, cancel, item_avail, bank_avail,
        output credit, dispense_item, change_coin, coin_reject, vend_deny, change_short, busy
    );
endinterface

// File: rtl/vending_controller.sv
// vending_controller: coin credit, fixed-price vend and greedy change/refund dispenser.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-low
//   bus   - vending_controller_if.slave carrying all panel, sensor and solenoid signals
module vending_controller #(
    parameter int NUM_ITEMS  = 6,
    parameter int PRICE      = 30,
    parameter int MAX_CREDIT = 40,
    parameter int CREDIT_W   = 8
) (
    input logic                  clk,
    input logic                  reset,
    vending_controller_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, VEND, CHANGE, REFUND} state_t;

    state_t               r_state;
    logic [CREDIT_W-1:0]  r_credit;
    logic [NUM_ITEMS-1:0] r_dispense;
    logic [4:0]           r_change;
    logic                 r_reject;
    logic                 r_deny;
    logic                 r_short;
    logic                 r_busy;

    logic [CREDIT_W-1:0]  w_base;
    logic [CREDIT_W-1:0]  w_rem;
    logic [4:0]           w_fit;
    logic [4:0]           w_pick;
    logic                 w_coin_ok;
    logic                 w_vend_ok;
    state_t               w_keep;

    function automatic logic [CREDIT_W-1:0] f_val(input logic [4:0] c);
        return c[4] ? CREDIT_W'(20) : c[3] ? CREDIT_W'(10) : c[2] ? CREDIT_W'(5) :
               c[1] ? CREDIT_W'(2)  : c[0] ? CREDIT_W'(1)  : '0;
    endfunction

    // The VEND cycle feeds the change engine with the post-price remainder so the
    // first change coin lands on the cycle right after the dispense pulse.
    always_comb begin
        w_base = (r_state == VEND) ? r_credit - CREDIT_W'(PRICE) : r_credit;
        for (int i = 0; i < 5; i++)
            w_fit[i] = bus.bank_avail[i] && (w_base >= f_val(5'(1 << i)));
        w_pick = w_fit[4] ? 5'b10000 : w_fit[3] ? 5'b01000 : w_fit[2] ? 5'b00100 :
                 w_fit[1] ? 5'b00010 : w_fit[0] ? 5'b00001 : 5'b00000;
        w_rem  = w_base - f_val(w_pick);
        w_coin_ok = $onehot(bus.coin) &&
                    ({1'b0, r_credit} + {1'b0, f_val(bus.coin)} <= (CREDIT_W+1)'(MAX_CREDIT));
        w_vend_ok = $onehot(bus.item_select) && (|(bus.item_select & bus.item_avail)) &&
                    (r_credit >= CREDIT_W'(PRICE));
        w_keep = (r_state == VEND || r_state == CHANGE) ? CHANGE : REFUND;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_credit   <= '0;
            r_dispense <= '0;
            r_change   <= '0;
            r_reject   <= 1'b0;
            r_deny     <= 1'b0;
            r_short    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_dispense <= '0;
            r_change   <= '0;
            r_reject   <= 1'b0;
            r_deny     <= 1'b0;
            r_short    <= 1'b0;
            if (r_state == IDLE && !(bus.cancel && r_credit != '0)) begin
                if (bus.vend_req && w_vend_ok) begin
                    r_dispense <= bus.item_select;
                    r_state    <= VEND;
                    r_busy     <= 1'b1;
                    r_reject   <= bus.coin_valid;
                end else begin
                    // A denied vend still lets a same-cycle coin through.
                    r_deny <= bus.vend_req;
                    if (bus.coin_valid) begin
                        if (w_coin_ok)
                            r_credit <= r_credit + f_val(bus.coin);
                        else
                            r_reject <= 1'b1;
                    end
                end
            end else begin
                // Accepted cancel or any busy state: run one step of the greedy engine.
                r_reject <= bus.coin_valid;
                if (w_base == '0) begin
                    r_credit <= '0;
                    r_state  <= IDLE;
                    r_busy   <= 1'b0;
                end else if (|w_pick) begin
                    r_change <= w_pick;
                    r_credit <= w_rem;
                    r_state  <= w_keep;
                    r_busy   <= 1'b1;
                end else begin
                    r_short  <= 1'b1;
                    r_credit <= w_base;
                    r_state  <= IDLE;
                    r_busy   <= 1'b0;
                end
            end
        end
    end

    assign bus.credit        = r_credit;
    assign bus.dispense_item = r_dispense;
    assign bus.change_coin   = r_change;
    assign bus.coin_reject   = r_reject;
    assign bus.vend_deny     = r_deny;
    assign bus.change_short  = r_short;
    assign bus.busy          = r_busy;
endmodule
